axil_sram: RTL and testbench
============================

AXIL_SRAM -- requirements
Module: axil_sram

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the fixed response delay in cycles (range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports araddr (in 32), arvalid (in 1) and arready (out 1) forming the read-address channel.
REQ-006 The block SHALL have ports rdata (out 32), rresp (out 2), rvalid (out 1) and rready (in 1) forming the read-data channel.
REQ-007 The block SHALL have ports awaddr (in 32), awvalid (in 1) and awready (out 1) forming the write-address channel.
REQ-008 The block SHALL have ports wdata (in 32), wstrb (in 4), wvalid (in 1) and wready (out 1) forming the write-data channel.
REQ-009 The block SHALL have ports bresp (out 2), bvalid (out 1) and bready (in 1) forming the write-response channel.

Function
REQ-010 A channel transfer SHALL occur on a rising edge where both valid and ready are high.
REQ-011 The read FSM SHALL have three states: R_IDLE -> R_WAIT on an AR transfer; R_WAIT -> R_RESP when the delay counter reaches 0; R_RESP -> R_IDLE on an R transfer.
REQ-012 With a delay of 0, the read FSM SHALL go R_IDLE -> R_RESP directly, so rvalid rises one cycle after the AR transfer.
REQ-013 arready SHALL be high only in R_IDLE, so at most one read is outstanding.
REQ-014 The word index SHALL be addr[DEPTH_LOG2+1:2], and addr[1:0] SHALL be ignored.
REQ-015 An address is out of range when addr[31:DEPTH_LOG2+2] is nonzero.
REQ-016 A read SHALL sample storage on the edge entering R_RESP.
REQ-017 An in-range read SHALL return rresp=2'b00; an out-of-range read SHALL return rresp=2'b10 with rdata=0.
REQ-018 rdata and rresp SHALL hold stable while rvalid is high and rready is low.
REQ-019 The write FSM SHALL have three states: W_IDLE, W_WAIT and W_RESP.
REQ-020 In W_IDLE, AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-021 awready SHALL drop after its AW transfer, and wready SHALL drop after its W transfer, until W_IDLE is re-entered.
REQ-022 The write FSM SHALL enter W_WAIT once both AW and W are held, or W_RESP directly when the delay is 0.
REQ-023 A write SHALL commit on the edge entering W_RESP, updating only bytes whose wstrb bit is 1.
REQ-024 An out-of-range write SHALL leave storage unchanged and return bresp=2'b10; otherwise bresp=2'b00.
REQ-025 wstrb=0 SHALL change nothing and return OKAY.
REQ-026 W_RESP SHALL go to W_IDLE on a B transfer.
REQ-027 The read and write FSMs SHALL operate concurrently.
REQ-028 If a read sample and a write commit to the same word fall on the same edge, the read SHALL return the pre-write data.
REQ-029 Each FSM SHALL load its delay counter on the edge the request completes (AR transfer; second of AW/W) and decrement it once per cycle.

Reset
REQ-030 While rst is low, both FSMs SHALL be held in their IDLE states, the delay counters at 0, and rvalid and bvalid at 0.
REQ-031 While rst is low, arready, awready and wready SHALL be 0, and rdata and rresp/bresp SHALL be 0.
REQ-032 On the first edge after rst rises, the ready outputs SHALL go high.
REQ-033 Storage contents SHALL NOT be reset.
REQ-034 A reset asserted mid-transaction SHALL abort it, and an uncommitted write SHALL NOT reach storage.

Configuration
REQ-035 When AXIL_SRAM_LFSR_DELAY_EN is defined, the block SHALL contain an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) reset to 8'h5A.
REQ-036 The LFSR SHALL advance every cycle, and each FSM's delay SHALL be lfsr[2:0] sampled when its counter loads; LATENCY SHALL be ignored.
REQ-037 When AXIL_SRAM_LFSR_DELAY_EN is undefined, the block SHALL contain no LFSR, and both delays SHALL equal LATENCY.

Verification
REQ-038 With LATENCY=2: write 0x0000_0010 data 0xDEADBEEF wstrb 4'hF, then read 0x10 -> bvalid 3 cycles after the last of AW/W, bresp 00; rvalid 3 cycles after AR, rdata 0xDEADBEEF, rresp 00.
REQ-039 Byte strobe: on word 0x11223344, write wdata 0xAABBCCDD wstrb 4'b0101 -> readback 0x11BB33DD.
REQ-040 Out of range with DEPTH_LOG2=10: read and write at 0x0000_1000 -> rresp 10 with rdata 0, bresp 10, and word 0 unchanged.
REQ-041 W before AW: assert wvalid 2 cycles before awvalid -> wready drops after the W transfer, and the commit happens only after AW.
REQ-042 Backpressure plus reset: hold rready=0 for 5 cycles -> rdata stable and arready=0; then pull rst low during W_WAIT -> after reset, the target word is unchanged and bvalid=0.

Source files
------------

// File: rtl/axil_sram.sv
// axil_sram: AXI4-Lite word SRAM with fixed latency (random 0..7 via LFSR when AXIL_SRAM_LFSR_DELAY_EN is defined)
module axil_sram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wState_e;

  logic [31:0] mem [2**DEPTH_LOG2];
  rState_e rState, rStateN;
  wState_e wState, wStateN;
  logic [3:0] rCnt, rCntN, wCnt, wCntN, delay;
  logic [31:2] arAddrQ, awAddrQ, rAddr, wAddr;
  logic [31:0] wDataQ, wData;
  logic [3:0] wStrbQ, wStrb;
  logic live, awHeld, wHeld;
  logic arFire, rFire, awFire, wFire, bFire;
  logic rSample, wCommit, rIn, wIn;
  logic unusedAddrLsb;

  assign unusedAddrLsb = ^{araddr[1:0], awaddr[1:0]};

`ifdef AXIL_SRAM_LFSR_DELAY_EN
  logic [7:0] lfsr;
  // Free-running Fibonacci LFSR x^8+x^6+x^5+x^4+1; low bits give each request's delay
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 8'h5A;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign delay = {1'b0, lfsr[2:0]};
`else
  assign delay = 4'(LATENCY);
`endif

  assign arready = live && rState == R_IDLE;
  assign awready = live && wState == W_IDLE && !awHeld;
  assign wready = live && wState == W_IDLE && !wHeld;
  assign rvalid = rState == R_RESP;
  assign bvalid = wState == W_RESP;
  assign arFire = arvalid && arready;
  assign rFire = rvalid && rready;
  assign awFire = awvalid && awready;
  assign wFire = wvalid && wready;
  assign bFire = bvalid && bready;
  assign rAddr = arFire ? araddr[31:2] : arAddrQ;
  assign wAddr = awFire ? awaddr[31:2] : awAddrQ;
  assign wData = wFire ? wdata : wDataQ;
  assign wStrb = wFire ? wstrb : wStrbQ;
  assign rIn = rAddr[31:DEPTH_LOG2+2] == '0;
  assign wIn = wAddr[31:DEPTH_LOG2+2] == '0;
  assign rSample = rStateN == R_RESP && rState != R_RESP;
  assign wCommit = rst && wStateN == W_RESP && wState != W_RESP;

  // Read FSM: accept one address, count down the delay, then present the response
  always_comb begin
    rStateN = rState;
    rCntN = rCnt;
    case (rState)
      R_IDLE: if (arFire) begin
        rStateN = delay == 4'd0 ? R_RESP : R_WAIT;
        rCntN = delay;
      end
      R_WAIT: begin
        rStateN = rCnt == 4'd0 ? R_RESP : R_WAIT;
        rCntN = rCnt == 4'd0 ? 4'd0 : rCnt - 4'd1;
      end
      R_RESP: if (rFire) rStateN = R_IDLE;
      default: rStateN = R_IDLE;
    endcase
  end

  // Write FSM: collect AW and W in any order, count down the delay, then respond
  always_comb begin
    wStateN = wState;
    wCntN = wCnt;
    case (wState)
      W_IDLE: if ((awHeld || awFire) && (wHeld || wFire)) begin
        wStateN = delay == 4'd0 ? W_RESP : W_WAIT;
        wCntN = delay;
      end
      W_WAIT: begin
        wStateN = wCnt == 4'd0 ? W_RESP : W_WAIT;
        wCntN = wCnt == 4'd0 ? 4'd0 : wCnt - 4'd1;
      end
      W_RESP: if (bFire) wStateN = W_IDLE;
      default: wStateN = W_IDLE;
    endcase
  end

  // State, counters, captured request fields and registered responses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      live <= 1'b0;
      rState <= R_IDLE;
      wState <= W_IDLE;
      rCnt <= '0;
      wCnt <= '0;
      awHeld <= 1'b0;
      wHeld <= 1'b0;
      arAddrQ <= '0;
      awAddrQ <= '0;
      wDataQ <= '0;
      wStrbQ <= '0;
      rdata <= '0;
      rresp <= '0;
      bresp <= '0;
    end else begin
      live <= 1'b1;
      rState <= rStateN;
      wState <= wStateN;
      rCnt <= rCntN;
      wCnt <= wCntN;
      awHeld <= wStateN == W_IDLE && (awHeld || awFire);
      wHeld <= wStateN == W_IDLE && (wHeld || wFire);
      if (arFire) arAddrQ <= araddr[31:2];
      if (awFire) awAddrQ <= awaddr[31:2];
      if (wFire) wDataQ <= wdata;
      if (wFire) wStrbQ <= wstrb;
      if (rSample) rdata <= rIn ? mem[rAddr[DEPTH_LOG2+1:2]] : '0;
      if (rSample) rresp <= rIn ? 2'b00 : 2'b10;
      if (wCommit) bresp <= wIn ? 2'b00 : 2'b10;
    end

  // Byte-masked commit into storage, which is never reset
  always_ff @(posedge clk)
    if (wCommit && wIn)
      for (int b = 0; b < 4; b++)
        if (wStrb[b]) mem[wAddr[DEPTH_LOG2+1:2]][8*b +: 8] <= wData[8*b +: 8];
endmodule

// File: tb/tb_axil_sram.sv
// tb_axil_sram: randomized self-checking bench for axil_sram against a word-array model
module tb_axil_sram;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] araddr = '0, rdata, awaddr = '0, wdata = '0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b1;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b1;
  logic [3:0] wstrb = '0;
  logic [1:0] rresp, bresp;
  int checks = 0, errors = 0;
  logic [31:0] model [0:1023];

  axil_sram #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle budget");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aDel, input int wDel, output logic [1:0] resp, output int lat);
    logic ad, wd, ah, wh;
    int n;
    awaddr = a; wdata = d; wstrb = s; ad = 0; wd = 0; n = 0;
    while (!(ad && wd) && n < 50) begin
      if (!ad && n >= aDel) awvalid = 1;
      if (!wd && n >= wDel) wvalid = 1;
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) begin awvalid = 0; ad = 1; end
      if (wh) begin wvalid = 0; wd = 1; end
      n++;
    end
    awvalid = 0; wvalid = 0;
    if (!(ad && wd)) begin lat = -1; resp = 2'bxx; return; end
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bvalid) begin lat = -1; resp = 2'bxx; return; end
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    araddr = a; arvalid = 1; n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rvalid) begin lat = -1; d = 'x; resp = 2'bxx; return; end
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({arready, awready, wready} !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", {arready, awready, wready}); end
    checks++; if ({rvalid, bvalid} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", {rvalid, bvalid}); end
    checks++; if ({rdata, rresp, bresp} !== 36'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {rdata, rresp, bresp}); end
    rst = 1;
    #1;
    checks++; if ({arready, awready, wready} !== 3'b000) begin errors++; $display("FAIL release_ready_early got %b exp 000", {arready, awready, wready}); end
    @(posedge clk); #1;
    checks++; if ({arready, awready, wready} !== 3'b111) begin errors++; $display("FAIL release_ready got %b exp 111", {arready, awready, wready}); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
    model[4] = 32'hDEADBEEF;
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_b_latency got %0d exp 3", lat); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b exp 00", r); end
    axi_read(32'h10, d, r, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_r_latency got %0d exp 3", lat); end
    checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin errors++; $display("FAIL basic_rdata got %h/%b exp deadbeef/00", d, r); end
    axi_read(32'h13, d, r, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL addr_lsb_ignored got %h exp deadbeef", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    axi_write(32'h20, 32'h11223344, 4'hF, 0, 0, r, lat);
    axi_write(32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, r, lat);
    model[8] = merge(32'h11223344, 32'hAABBCCDD, 4'b0101);
    axi_read(32'h20, d, r, lat);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got %h exp 11bb33dd", d); end
    axi_write(32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strobe_zero_bresp got %b exp 00", r); end
    axi_read(32'h20, d, r, lat);
    checks++; if (d !== model[8]) begin errors++; $display("FAIL strobe_zero_data got %h exp %h", d, model[8]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    axi_write(32'h0, 32'h0BADF00D, 4'hF, 0, 0, r, lat);
    model[0] = 32'h0BADF00D;
    axi_write(32'h1000, 32'h12345678, 4'hF, 0, 0, r, lat);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b exp 10", r); end
    axi_read(32'h1000, d, r, lat);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read got %h/%b exp 0/10", d, r); end
    axi_read(32'h0, d, r, lat);
    checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL oor_word0 got %h exp 0badf00d", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    wdata = 32'hC0FFEE11; wstrb = 4'hF; wvalid = 1;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b exp 1", wready); end
    @(posedge clk); #1;
    wvalid = 0;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_drop got %b exp 0", wready); end
    @(posedge clk); #1;
    checks++; if ({wready, awready, bvalid} !== 3'b010) begin errors++; $display("FAIL wfirst_hold got %b exp 010", {wready, awready, bvalid}); end
    awaddr = 32'hC0; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 3 || bresp !== 2'b00) begin errors++; $display("FAIL wfirst_b got lat %0d resp %b exp 3/00", lat, bresp); end
    @(posedge clk); #1;
    model[48] = 32'hC0FFEE11;
    axi_read(32'hC0, d, r, lat);
    checks++; if (d !== 32'hC0FFEE11) begin errors++; $display("FAIL wfirst_data got %h exp c0ffee11", d); end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [1:0] r;
    int lat, n;
    axi_write(32'h40, 32'h01020304, 4'hF, 0, 0, r, lat);
    araddr = 32'h40; arvalid = 1;
    awaddr = 32'h40; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    checks++; if ({arready, awready, wready} !== 3'b111) begin errors++; $display("FAIL same_edge_ready got %b exp 111", {arready, awready, wready}); end
    @(posedge clk); #1;
    arvalid = 0; awvalid = 0; wvalid = 0;
    n = 0;
    while (!(rvalid && bvalid) && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3 || rdata !== 32'h01020304) begin errors++; $display("FAIL same_edge_old got %h after %0d exp 01020304 after 3", rdata, n); end
    @(posedge clk); #1;
    model[16] = 32'hA5A5A5A5;
    axi_read(32'h40, d, r, lat);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL same_edge_new got %h exp a5a5a5a5", d); end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] d;
    logic [1:0] r;
    int lat, n;
    axi_write(32'h80, 32'h5EED1234, 4'hF, 0, 0, r, lat);
    model[32] = 32'h5EED1234;
    rready = 0; araddr = 32'h80; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h5EED1234 || rresp !== 2'b00 || arready !== 1'b0) begin errors++; $display("FAIL backpressure_hold cyc %0d got v%b %h/%b ar%b exp 1 5eed1234/00 0", i, rvalid, rdata, rresp, arready); end
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL backpressure_release got %b exp 0", rvalid); end
    awaddr = 32'h80; wdata = 32'hFFFF0000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    rst = 0;
    #1;
    checks++; if ({bvalid, awready, wready, arready} !== 4'b0000) begin errors++; $display("FAIL reset_abort_outputs got %b exp 0000", {bvalid, awready, wready, arready}); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_abort_bvalid cyc %0d got %b exp 0", i, bvalid); end
    end
    rst = 1;
    @(posedge clk); #1;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_abort_after got %b exp 0", bvalid); end
    axi_read(32'h80, d, r, lat);
    checks++; if (d !== 32'h5EED1234) begin errors++; $display("FAIL reset_abort_data got %h exp 5eed1234", d); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got;
    logic [3:0] s;
    logic [1:0] r;
    logic inR;
    int lat;
    for (int i = 64; i < 80; i++) begin
      d = $urandom;
      axi_write(32'(i * 4), d, 4'hF, 0, 0, r, lat);
      model[i] = d;
    end
    for (int k = 0; k < 100; k++) begin
      a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      inR = a[31:12] == 20'h0;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, lat);
        checks++; if (r !== (inR ? 2'b00 : 2'b10) || lat !== 3) begin errors++; $display("FAIL rand_write %h got resp %b lat %0d exp %b/3", a, r, lat, inR ? 2'b00 : 2'b10); end
        if (inR) model[a[11:2]] = merge(model[a[11:2]], d, s);
      end else begin
        axi_read(a, got, r, lat);
        d = inR ? model[a[11:2]] : 32'h0;
        checks++; if (got !== d || r !== (inR ? 2'b00 : 2'b10) || lat !== 3) begin errors++; $display("FAIL rand_read %h got %h/%b lat %0d exp %h/%b/3", a, got, r, lat, d, inR ? 2'b00 : 2'b10); end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_out_of_range();
    test_w_before_aw();
    test_same_edge();
    test_backpressure_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
